// File: rtl/top_scheduler_up.sv
// top_scheduler_up: routes whole host packets to one of several TX streams by tdest,
// dropping and counting packets that are out of range or start while disabled.
module top_scheduler_up #(
    parameter int IF_COUNT_UP_TX  = 3,
    parameter int AXIS_DATA_WIDTH = 64,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH/8,
    parameter int AXIS_DEST_WIDTH = 2,
    parameter int COUNTER_WIDTH   = 32
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [AXIS_DATA_WIDTH-1:0]                s_axis_top_scheduler_up_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0]                s_axis_top_scheduler_up_tkeep,
    input  logic                                      s_axis_top_scheduler_up_tvalid,
    output logic                                      s_axis_top_scheduler_up_tready,
    input  logic                                      s_axis_top_scheduler_up_tlast,
    input  logic [AXIS_DEST_WIDTH-1:0]                s_axis_top_scheduler_up_tdest,
    output logic [IF_COUNT_UP_TX*AXIS_DATA_WIDTH-1:0] m_axis_top_scheduler_up_tdata,
    output logic [IF_COUNT_UP_TX*AXIS_KEEP_WIDTH-1:0] m_axis_top_scheduler_up_tkeep,
    output logic [IF_COUNT_UP_TX-1:0]                 m_axis_top_scheduler_up_tvalid,
    input  logic [IF_COUNT_UP_TX-1:0]                 m_axis_top_scheduler_up_tready,
    output logic [IF_COUNT_UP_TX-1:0]                 m_axis_top_scheduler_up_tlast,
    input  logic                                      w_enable_dp,
    input  logic                                      w_rst_drop_counter,
    output logic [COUNTER_WIDTH-1:0]                  w_drop_counter,
    output logic [IF_COUNT_UP_TX*COUNTER_WIDTH-1:0]   w_tx_packet_counter
);
    typedef enum logic [1:0] {IDLE, FORWARD, DROP} state_t;
    state_t state_q, state_d;
    logic out_v_q, out_v_d, last_q, last_d;
    logic [AXIS_DATA_WIDTH-1:0] data_q, data_d;
    logic [AXIS_KEEP_WIDTH-1:0] keep_q, keep_d;
    logic [AXIS_DEST_WIDTH-1:0] sel_q, sel_d;
    logic [COUNTER_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic [COUNTER_WIDTH-1:0] tx_cnt_q [IF_COUNT_UP_TX];
    logic [COUNTER_WIDTH-1:0] tx_cnt_d [IF_COUNT_UP_TX];
    logic hs, fwd, load, drain, drop_inc;

    always_comb begin
        s_axis_top_scheduler_up_tready = rst ? 1'b0 :
            state_q == IDLE    ? !out_v_q :
            state_q == FORWARD ? (!out_v_q || m_axis_top_scheduler_up_tready[sel_q]) : 1'b1;
        hs       = s_axis_top_scheduler_up_tvalid && s_axis_top_scheduler_up_tready;
        fwd      = w_enable_dp && (32'(s_axis_top_scheduler_up_tdest) < IF_COUNT_UP_TX);
        load     = hs && (state_q == IDLE ? fwd : state_q == FORWARD);
        drop_inc = hs && state_q == IDLE && !fwd;
        drain    = out_v_q && m_axis_top_scheduler_up_tready[sel_q];
        state_d  = state_q;
        if (hs)
            state_d = s_axis_top_scheduler_up_tlast ? IDLE :
                      state_q != IDLE ? state_q : fwd ? FORWARD : DROP;
        out_v_d = load || (out_v_q && !drain);
        data_d  = load ? s_axis_top_scheduler_up_tdata : data_q;
        keep_d  = load ? s_axis_top_scheduler_up_tkeep : keep_q;
        last_d  = load ? s_axis_top_scheduler_up_tlast : last_q;
        sel_d   = (load && state_q == IDLE) ? s_axis_top_scheduler_up_tdest : sel_q;
        // counter clear wins over any same-cycle increment; increments saturate
        drop_cnt_d = w_rst_drop_counter ? '0 :
                     (drop_inc && !(&drop_cnt_q)) ? drop_cnt_q + 1'b1 : drop_cnt_q;
        for (int i = 0; i < IF_COUNT_UP_TX; i++)
            tx_cnt_d[i] = w_rst_drop_counter ? '0 :
                          (drain && last_q && 32'(sel_q) == i && !(&tx_cnt_q[i])) ?
                          tx_cnt_q[i] + 1'b1 : tx_cnt_q[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            out_v_q    <= 1'b0;
            last_q     <= 1'b0;
            data_q     <= '0;
            keep_q     <= '0;
            sel_q      <= '0;
            drop_cnt_q <= '0;
            for (int i = 0; i < IF_COUNT_UP_TX; i++) tx_cnt_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            out_v_q    <= out_v_d;
            last_q     <= last_d;
            data_q     <= data_d;
            keep_q     <= keep_d;
            sel_q      <= sel_d;
            drop_cnt_q <= drop_cnt_d;
            for (int i = 0; i < IF_COUNT_UP_TX; i++) tx_cnt_q[i] <= tx_cnt_d[i];
        end
    end

    assign m_axis_top_scheduler_up_tdata  = {IF_COUNT_UP_TX{data_q}};
    assign m_axis_top_scheduler_up_tkeep  = {IF_COUNT_UP_TX{keep_q}};
    assign m_axis_top_scheduler_up_tvalid = IF_COUNT_UP_TX'(out_v_q) << sel_q;
    assign m_axis_top_scheduler_up_tlast  = IF_COUNT_UP_TX'(out_v_q && last_q) << sel_q;
    assign w_drop_counter = drop_cnt_q;

    for (genvar g = 0; g < IF_COUNT_UP_TX; g++) begin : g_cnt
        assign w_tx_packet_counter[g*COUNTER_WIDTH +: COUNTER_WIDTH] = tx_cnt_q[g];
    end
endmodule
